sr_drive_ctrl: RTL
==================

# sr_drive_ctrl

Command-side controller for the team's clocked SR flip-flop (`s`, `r` in; `q` out). It accepts level requests over a valid/ready handshake and turns each one into a timed set or reset pulse followed by a settle window. It guarantees that `s` and `r` are never high together. Optionally it confirms the flop's `q` through a feedback input and flags a timeout. It sits between control logic and any SR-style storage element.

## Interface
- `PULSE_W`, default 2: cycles `s` or `r` is held high per command; legal range 1..15.
- `SETTLE_W`, default 1: cycles with `s`=`r`=0 after the pulse; legal range 0..15.
- `TIMEOUT`, default 8: feedback cycles allowed before error; legal range 1..255. Used only with the feedback feature.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the controller can accept a request.
- `req_level` in 1: target level; 1 means set, 0 means reset.
- `req_force` in 1: drive the pulse even if the tracked level already equals `req_level`.
- `s` out 1: set drive to the flop, registered.
- `r` out 1: reset drive to the flop, registered.
- `q_fb` in 1: the flop's `q`. Used only with the feedback feature.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse on feedback timeout.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK (CHECK exists only with the feedback feature).
- Internal tracked level `lvl` resets to 0, matching the flop's reset value. Internal `lvl_ok` resets to 1.
- IDLE: `req_ready`=1. A request is accepted on an edge where `req_valid`&`req_ready`=1; `req_level` and `req_force` are captured at that edge.
- Skip case: accepted with `req_force`=0, `lvl_ok`=1 and `req_level`=`lvl`.
  - The controller stays in IDLE and drives no pulse.
  - `done` pulses the next cycle.
- Otherwise the controller moves to DRIVE.
  - `s`=`req_level` and `r`=~`req_level` for exactly `PULSE_W` cycles.
  - It then moves to SETTLE for `SETTLE_W` cycles with `s`=`r`=0. If `SETTLE_W`=0, SETTLE is skipped.
- After SETTLE, without the feedback feature:
  - Return to IDLE.
  - `done` pulses.
  - `lvl` takes the captured level and `lvl_ok` is set to 1.
- Invariant: `s`&`r`=0 in every cycle, including during and after reset.
- A new request cannot be accepted while busy; `req_ready`=0 outside IDLE.

## Timing
- Reset values: `s`=0, `r`=0, `done`=0, `err`=0, `busy`=0. `req_ready`=0 while `rst`=1 and 1 in the first cycle after reset.
- Let the accept edge be T.
  - `s`/`r` are high in cycles T+1 .. T+`PULSE_W`.
  - Settle covers T+`PULSE_W`+1 .. T+`PULSE_W`+`SETTLE_W`.
- Without feedback:
  - `done`=1 in cycle T+`PULSE_W`+`SETTLE_W`+1.
  - IDLE and `req_ready`=1 in that same cycle, so back-to-back accept is allowed there.
  - Default latency from accept to `done` is 4 cycles.
- Skip case: `done`=1 in cycle T+1. `req_ready` stays 1 throughout.
- Reset mid-operation: at the next edge `s`=`r`=0, state IDLE, `lvl`=0, `lvl_ok`=1. No `done` or `err` is produced.
- `req_valid` deasserting while `req_ready`=0 is legal and has no effect.

## Configuration
- Macro: `SR_DRIVE_CTRL_FB_CHECK_EN`.
- Defined:
  - SETTLE goes to CHECK.
  - CHECK samples `q_fb` each edge.
  - On a match with the captured level: the next cycle has `done`=1 and the controller is in IDLE; `lvl` is updated and `lvl_ok`=1.
  - After `TIMEOUT` consecutive mismatches: the next cycle has `err`=1 and the controller is in IDLE; `lvl_ok`=0, so the next request is always driven regardless of `req_force`.
  - Minimum latency is T+`PULSE_W`+`SETTLE_W`+2.
- Undefined:
  - There is no CHECK state and `q_fb` is ignored.
  - `err` is tied to 0.

## Structure
- A shared package `sr_pkg` holds:
  - the state enum `sr_drv_state_t` (IDLE, DRIVE, SETTLE, CHECK);
  - the width constant `SR_CNT_W`=8 for the pulse, settle and timeout counter;
  - the level constants `SR_LVL_SET`=1 and `SR_LVL_RST`=0.
- One sub-module is natural: `sr_pulse_timer`, a loadable down-counter with a zero flag, shared by the DRIVE, SETTLE and CHECK phases.

## Test plan
- After reset, request `level`=1, `force`=0, default parameters: `s`=1 for cycles T+1..T+2, `r` stays 0, `done` at T+4, `req_ready`=1 at T+4.
- Immediately repeat `level`=1 with `force`=0: no `s`/`r` activity, `done` at T+1. Repeat with `force`=1: a full pulse is driven again.
- Set, then reset, back-to-back with `PULSE_W`=3, `SETTLE_W`=0: `r` high for 3 cycles, and `s`&`r` is never 1 in any cycle.
- Assert `rst` in the second DRIVE cycle: `s`=0 at the next edge, no `done`, `lvl`=0; a following `level`=0 `force`=0 request skips.
- With `SR_DRIVE_CTRL_FB_CHECK_EN`, `q_fb` following the pulse: `done` at T+5.
- With `SR_DRIVE_CTRL_FB_CHECK_EN`, `q_fb` stuck at 0, `level`=1, `TIMEOUT`=8: `err` pulses once after 8 CHECK cycles, and the next `force`=0 request is still driven.

Source files
------------

// File: rtl/sr_drive_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared types and constants for the SR flip-flop drive controller.
//   sr_drv_state_t : controller state encoding
//   SR_CNT_W       : width of the shared pulse/settle/timeout down-counter
//   SR_LVL_SET/RST : level encodings (1 = set, 0 = reset)
//   sr_cnt_load()  : converts a cycle count into a down-counter load value
// -----------------------------------------------------------------------------
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } sr_drv_state_t;

  localparam int   SR_CNT_W   = 8;
  localparam logic SR_LVL_SET = 1'b1;
  localparam logic SR_LVL_RST = 1'b0;

  // The timer reaches zero on the last cycle of a phase, so a phase lasting
  // N cycles loads N-1.
  function automatic logic [SR_CNT_W-1:0] sr_cnt_load(input int unsigned cycles);
    int unsigned v;
    v = (cycles == 0) ? 0 : cycles - 1;
    return SR_CNT_W'(v);
  endfunction

endpackage

// File: rtl/sr_drive_ctrl_timer.sv
// -----------------------------------------------------------------------------
// sr_pulse_timer
// Loadable down-counter with a zero flag. Counts down once per cycle and
// holds at zero. Shared by the DRIVE, SETTLE and CHECK phases.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this edge (overrides counting)
//   load_val : value to load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SR_CNT_W-1:0] load_val,
  output logic                zero
);

  logic [SR_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
// Command-side controller for a clocked SR flip-flop. Each accepted request
// becomes a PULSE_W-cycle set or reset pulse followed by a SETTLE_W-cycle
// quiet window. s and r are never high together.
//
// Optional feature (macro SR_DRIVE_CTRL_FB_CHECK_EN): after the settle window
// the controller waits for q_fb to match the requested level and raises err
// after TIMEOUT consecutive mismatches. Without the macro q_fb is ignored and
// err is tied low.
//
// State  | meaning
// IDLE   | ready for a request; skip-case requests complete here
// DRIVE  | s or r held high for PULSE_W cycles
// SETTLE | s = r = 0 for SETTLE_W cycles (bypassed when SETTLE_W = 0)
// CHECK  | waiting for q_fb to confirm the level (feedback build only)
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : request present
//   req_ready : request can be accepted (IDLE and not in reset)
//   req_level : target level (1 = set, 0 = reset)
//   req_force : pulse even if the tracked level already matches
//   s, r      : registered set/reset drives to the flop
//   q_fb      : flop output feedback
//   busy      : not in IDLE
//   done      : one-cycle completion pulse
//   err       : one-cycle feedback timeout pulse
// -----------------------------------------------------------------------------
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 1,
  parameter int TIMEOUT  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_level,
  input  logic req_force,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err
);

  sr_drv_state_t       state;
  logic                lvl;
  logic                lvl_ok;
  logic                cap_lvl;
  logic                accept;
  logic                skip_now;
  logic                accept_drive;
  logic                go_settle;
  logic                phase_end;
  logic                tmr_load;
  logic                tmr_zero;
  logic [SR_CNT_W-1:0] tmr_val;

  assign req_ready    = (state == IDLE) && !rst;
  assign busy         = (state != IDLE);
  assign accept       = req_valid && req_ready;
  // lvl_ok = 0 after a feedback timeout: the flop state is unknown, so the
  // next request is always driven.
  assign skip_now     = !req_force && lvl_ok && (req_level == lvl);
  assign accept_drive = accept && !skip_now;
  assign go_settle    = (state == DRIVE) && tmr_zero && (SETTLE_W != 0);
  // End of the drive/settle sequence: last settle cycle, or last drive cycle
  // when there is no settle window.
  assign phase_end    = tmr_zero &&
                        (((state == DRIVE) && (SETTLE_W == 0)) || (state == SETTLE));

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept_drive) begin
      tmr_load = 1'b1;
      tmr_val  = sr_cnt_load(PULSE_W);
    end else if (go_settle) begin
      tmr_load = 1'b1;
      tmr_val  = sr_cnt_load(SETTLE_W);
    end else if (phase_end) begin
      // Only meaningful when CHECK follows; harmless otherwise.
      tmr_load = 1'b1;
      tmr_val  = sr_cnt_load(TIMEOUT);
    end
  end

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef SR_DRIVE_CTRL_FB_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= 1'b0;
      r       <= 1'b0;
      done    <= 1'b0;
      lvl     <= SR_LVL_RST;
      lvl_ok  <= 1'b1;
      cap_lvl <= SR_LVL_RST;
`ifdef SR_DRIVE_CTRL_FB_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SR_DRIVE_CTRL_FB_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            cap_lvl <= req_level;
            if (skip_now) begin
              done <= 1'b1;
            end else begin
              state <= DRIVE;
              s     <= req_level;
              r     <= ~req_level;
            end
          end
        end
        DRIVE: begin
          if (tmr_zero) begin
            s <= 1'b0;
            r <= 1'b0;
            if (SETTLE_W != 0) state <= SETTLE;
          end
        end
        SETTLE: begin
        end
`ifdef SR_DRIVE_CTRL_FB_CHECK_EN
        CHECK: begin
          if (q_fb == cap_lvl) begin
            state  <= IDLE;
            done   <= 1'b1;
            lvl    <= cap_lvl;
            lvl_ok <= 1'b1;
          end else if (tmr_zero) begin
            state  <= IDLE;
            err_q  <= 1'b1;
            lvl_ok <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      if (phase_end) begin
`ifdef SR_DRIVE_CTRL_FB_CHECK_EN
        state <= CHECK;
`else
        state  <= IDLE;
        done   <= 1'b1;
        lvl    <= cap_lvl;
        lvl_ok <= 1'b1;
`endif
      end
    end
  end

endmodule
